// File: rtl/cl_dram_matrix_axi_resp_if.sv
// cl_dram_matrix_axi_resp_if: AXI4 AW/W/B/AR/R bus; master modport drives requests, slave modport drives responses
interface cl_dram_matrix_axi_resp_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W = 16
);
  logic [ID_W-1:0] awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic awvalid;
  logic awready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic wlast;
  logic wvalid;
  logic wready;
  logic [ID_W-1:0] bid;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [ID_W-1:0] arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic arvalid;
  logic arready;
  logic [ID_W-1:0] rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport master (
    output awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/cl_dram_matrix_axi_resp.sv
// cl_dram_matrix_axi_resp: AXI4 INCR-burst responder over on-chip 64-byte-word memory; ports clk, rst (sync, active-high), s_axi (slave modport)
module cl_dram_matrix_axi_resp #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input logic clk,
  input logic rst,
  cl_dram_matrix_axi_resp_if.slave s_axi
);
  localparam int WA_W = ADDR_W - 6;
  localparam int NB = DATA_W / 8;
  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];
  r_state_t r_state_q;
  logic [WA_W-1:0] r_addr_q, r_addr_d;
  logic [7:0] r_len_q, r_cnt_q;
  logic [ID_W-1:0] rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0] rresp_q;
  logic rlast_q, rvalid_q, arready_q, r_ok;
  w_state_t w_state_q;
  logic [WA_W-1:0] w_addr_q;
  logic [7:0] w_len_q, w_cnt_q;
  logic [ID_W-1:0] bid_q;
  logic [1:0] bresp_q;
  logic awready_q, wready_q, bvalid_q, w_err_q, w_ok, w_fire;
  logic unused_ok;
  assign unused_ok = ^{s_axi.awsize, s_axi.arsize, s_axi.wlast, s_axi.awaddr[5:0], s_axi.araddr[5:0]};
  assign r_addr_d = (r_state_q == R_IDLE) ? s_axi.araddr[ADDR_W-1:6] : r_addr_q + 1'b1;
  assign r_ok = (r_addr_d >> DEPTH_LOG2) == '0;
  assign w_ok = (w_addr_q >> DEPTH_LOG2) == '0;
  assign w_fire = !rst && w_state_q == W_DATA && s_axi.wvalid;
  always_ff @(posedge clk)
    if (rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q <= 1'b0;
      rid_q <= '0;
      rresp_q <= '0;
      rdata_q <= '0;
      r_addr_q <= '0;
      r_len_q <= '0;
      r_cnt_q <= '0;
    end else if (r_state_q == R_IDLE) begin
      arready_q <= 1'b1;
      if (s_axi.arvalid && arready_q) begin
        r_state_q <= R_BURST;
        arready_q <= 1'b0;
        rvalid_q <= 1'b1;
        rid_q <= s_axi.arid;
        r_addr_q <= r_addr_d;
        r_len_q <= s_axi.arlen;
        r_cnt_q <= '0;
        rlast_q <= s_axi.arlen == 8'd0;
        rdata_q <= r_ok ? mem[r_addr_d[DEPTH_LOG2-1:0]] : '0;
        rresp_q <= r_ok ? 2'b00 : 2'b10;
      end
    end else if (s_axi.rready) begin
      if (rlast_q) begin
        r_state_q <= R_IDLE;
        arready_q <= 1'b1;
        rvalid_q <= 1'b0;
        rlast_q <= 1'b0;
      end else begin
        r_addr_q <= r_addr_d;
        r_cnt_q <= r_cnt_q + 8'd1;
        rlast_q <= r_cnt_q + 8'd1 == r_len_q;
        rdata_q <= r_ok ? mem[r_addr_d[DEPTH_LOG2-1:0]] : '0;
        rresp_q <= r_ok ? 2'b00 : 2'b10;
      end
    end
  always_ff @(posedge clk)
    if (w_fire && w_ok)
      for (int b = 0; b < NB; b++)
        if (s_axi.wstrb[b]) mem[w_addr_q[DEPTH_LOG2-1:0]][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
  always_ff @(posedge clk)
    if (rst) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bid_q <= '0;
      bresp_q <= '0;
      w_addr_q <= '0;
      w_len_q <= '0;
      w_cnt_q <= '0;
      w_err_q <= 1'b0;
    end else if (w_state_q == W_IDLE) begin
      awready_q <= 1'b1;
      if (s_axi.awvalid && awready_q) begin
        w_state_q <= W_DATA;
        awready_q <= 1'b0;
        wready_q <= 1'b1;
        bid_q <= s_axi.awid;
        w_addr_q <= s_axi.awaddr[ADDR_W-1:6];
        w_len_q <= s_axi.awlen;
        w_cnt_q <= '0;
        w_err_q <= 1'b0;
      end
    end else if (w_state_q == W_DATA) begin
      if (s_axi.wvalid) begin
        w_addr_q <= w_addr_q + 1'b1;
        w_cnt_q <= w_cnt_q + 8'd1;
        w_err_q <= w_err_q || !w_ok;
        if (w_cnt_q == w_len_q) begin
          w_state_q <= W_RESP;
          wready_q <= 1'b0;
          bvalid_q <= 1'b1;
          bresp_q <= (w_err_q || !w_ok) ? 2'b10 : 2'b00;
        end
      end
    end else if (s_axi.bready) begin
      w_state_q <= W_IDLE;
      bvalid_q <= 1'b0;
      awready_q <= 1'b1;
      w_err_q <= 1'b0;
    end
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid = rvalid_q;
  assign s_axi.rlast = rlast_q;
  assign s_axi.rid = rid_q;
  assign s_axi.rresp = rresp_q;
  assign s_axi.rdata = rdata_q;
  assign s_axi.awready = awready_q;
  assign s_axi.wready = wready_q;
  assign s_axi.bvalid = bvalid_q;
  assign s_axi.bid = bid_q;
  assign s_axi.bresp = bresp_q;
endmodule

// File: doc/cl_dram_matrix_axi_resp.md
# cl_dram_matrix_axi_resp

AXI4 responder (slave) backed by on-chip 512-bit-wide memory; it serves the read and write bursts issued by the matrix-calc AXI master. It sits on the master's AXI bus in place of the DDR path, for block-level simulation and small on-chip workloads. It supports one outstanding read and one outstanding write, INCR bursts, and byte-strobed writes.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 512, data width; fixed to 64-byte words
- ID_W, 16, AXI ID width
- DEPTH_LOG2, 10, log2 of memory depth in 64-byte words

Ports:
- clk  in  1  sole clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- awid / awaddr / awlen / awsize / awvalid  in  ID_W / ADDR_W / 8 / 3 / 1  write address channel
- awready  out  1  write address accept
- wdata / wstrb / wlast / wvalid  in  DATA_W / DATA_W/8 / 1 / 1  write data channel
- wready  out  1  write data accept
- bid / bresp / bvalid  out  ID_W / 2 / 1  write response
- bready  in  1  write response accept
- arid / araddr / arlen / arsize / arvalid  in  ID_W / ADDR_W / 8 / 3 / 1  read address channel
- arready  out  1  read address accept
- rid / rdata / rresp / rlast / rvalid  out  ID_W / DATA_W / 2 / 1 / 1  read data channel
- rready  in  1  read data accept

## Operation
- Word index = addr[DEPTH_LOG2+5:6]; addr[5:0] is ignored. Every beat carries or accepts the full 64-byte word, and the master selects lanes. awsize/arsize are captured but do not alter addressing.
- In-range test: addr >> (DEPTH_LOG2+6) == 0, evaluated per beat.
- Each beat advances the word index by 1. INCR only; burst type is ignored.
- Read FSM R_IDLE -> R_BURST -> R_IDLE:
  - R_IDLE: arready=1. AR handshake captures arid, index, arlen and clears the beat counter.
  - R_BURST: rvalid=1; rid is the captured ID; rlast=1 when beat counter == len.
  - Each R handshake advances index and counter. The last-beat handshake returns the FSM to R_IDLE.
  - Out-of-range beat: rdata=0, rresp=2'b10 (SLVERR). Otherwise rresp=2'b00.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1, wready=0. W beats offered before the AW handshake are stalled, never dropped.
  - W_DATA: wready=1. Each handshake writes bytes whose wstrb bit is 1; wstrb=0 writes nothing.
  - Termination is by beat count == awlen; wlast is ignored.
  - Out-of-range beat: data discarded and a sticky error flag set.
  - W_RESP: bvalid=1, bid is the captured ID, bresp=2'b10 if the error flag is set, else 2'b00. The B handshake returns the FSM to W_IDLE and clears the flag.
- Read and write FSMs are fully independent and run concurrently.
- Memory contents are not initialised by reset.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0; bid, bresp, rid, rresp, rdata = 0. awready and arready rise the first cycle after rst deasserts.
- Read latency: AR handshake at cycle T gives rvalid=1 at T+1.
- Read throughput: beats are back-to-back (1 per cycle) while rready=1. rready=0 holds rid/rdata/rresp/rlast stable.
- arready is 0 from T+1 until the cycle after the last R handshake.
- Write timing: AW handshake at T gives wready=1 at T+1, one beat per cycle. Last W handshake at T2 gives wready=0 and bvalid=1 at T2+1. bvalid holds until bready; awready=1 the cycle after the B handshake.
- Write visibility: a write beat at cycle T is visible to a read beat fetched at T+1 or later.
- Same-word collision: a read and a write to the same word in the same cycle returns the old data (read-first).
- Burst length 0 (awlen/arlen=0) is a single beat with rlast=1 on it.
- Index wrap: indices past depth-1 within a burst keep incrementing the full address. Beats beyond the range are therefore SLVERR, not aliased.
- rst mid-burst: at the next edge all outputs return to reset values, both FSMs go to idle, the partial burst is abandoned, and beats already written persist.

## Test plan
- Write awaddr=0x40, awlen=0, wstrb all-1s, wdata=pattern A; then read araddr=0x40, arlen=0 -> bresp=0, bid echoes awid=0x5; rdata=A, rlast=1, rvalid exactly 1 cycle after AR handshake.
- Write awlen=15 from 0x0 with data=beat index; read arlen=15 with rready held 1 -> 16 back-to-back beats, rdata=0..15, rlast only on beat 15, arready returns the cycle after.
- Read burst of 4 with rready toggling 1,0,0,1,... -> every beat held stable while stalled, no beat lost or duplicated.
- Write wstrb=0 over word holding A, then wstrb=0x...000F with data B -> word unchanged after the first write; after the second, only bytes 0-3 equal B, the rest equal A.
- Read araddr = (depth-1)*64, arlen=1 -> beat 0 OKAY with stored data, beat 1 rresp=2'b10 with rdata=0. A write straddling the same boundary -> bresp=2'b10.
- Assert rst during the 3rd beat of a 16-beat read and a concurrent write -> next cycle rvalid=0, bvalid=0, wready=0; arready/awready=1 one cycle after release; a new burst completes normally.
